// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - readout FSM states, word-to-byte split and TX guard constant
// READOUT_CHECKSUM_EN adds the CHK_SEND/CHK_WAIT states.
package uart_pkg;

  localparam int TX_GUARD_CYCLES = 1;

  typedef enum logic [3:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO,
`ifdef READOUT_CHECKSUM_EN
    CHK_SEND,
    CHK_WAIT,
`endif
    DONE
  } readout_state_t;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } byte_pair_t;

  // Word arrives zero-extended to 16 bits, so the upper byte is already padded.
  function automatic byte_pair_t split_word(input logic [15:0] word);
    byte_pair_t pair;
    pair.hi = word[15:8];
    pair.lo = word[7:0];
    return pair;
  endfunction

endpackage

// File: rtl/tx_byte_sender.sv
// rtl/tx_byte_sender.sv - start/busy handshake for one byte to the UART transmitter
module tx_byte_sender
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       go,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       sent
);

  localparam int GW = (TX_GUARD_CYCLES > 0) ? $clog2(TX_GUARD_CYCLES + 1) : 1;

  logic [7:0]    held;
  logic          waiting;
  logic [GW-1:0] guard;

  assign tx_start = go && !waiting && !tx_busy;
  assign tx_data  = go ? data : held;
  // The transmitter raises busy one cycle late, so the guard hides that gap.
  assign sent     = waiting && (guard == '0) && !tx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      held    <= 8'h00;
      waiting <= 1'b0;
      guard   <= '0;
    end else if (tx_start) begin
      held    <= data;
      waiting <= 1'b1;
      guard   <= GW'(TX_GUARD_CYCLES);
    end else if (waiting) begin
      if (guard != '0) begin
        guard <= guard - 1'b1;
      end else if (!tx_busy) begin
        waiting <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bram_readout_tx.sv
// rtl/bram_readout_tx.sv - reads a run of BRAM words and sends each as two UART bytes
// READOUT_CHECKSUM_EN appends an XOR checksum byte after the last word.
module bram_readout_tx
  import uart_pkg::*;
#(
  parameter int MEMORY_DEPTH = 1024,
  parameter int DATA_WIDTH   = 10,
  parameter int ADDR_WIDTH   = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0]   MAX_LEN   = (ADDR_WIDTH + 1)'(MEMORY_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_DEPTH - 1);
`ifdef READOUT_CHECKSUM_EN
  localparam readout_state_t AFTER_LAST = CHK_SEND;
`else
  localparam readout_state_t AFTER_LAST = DONE;
`endif

  readout_state_t      state, next_state;
  logic [ADDR_WIDTH:0] len_q, word_cnt, cnt_next;
  logic [15:0]         word_q;
  byte_pair_t          bytes;
  logic [7:0]          send_byte;
  logic                send_go, sent, accept, word_done;
`ifdef READOUT_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  assign bytes     = split_word(word_q);
  assign cnt_next  = word_cnt + 1'b1;
  assign accept    = (state == IDLE) && start;
  assign word_done = (state == WAIT_LO) && sent;

  assign bram_en = (state == RD_ISSUE);
  assign done    = (state == DONE);
  assign busy    = (state != IDLE) && (state != DONE);

  tx_byte_sender u_sender (
    .clk      (clk),
    .rst      (rst),
    .data     (send_byte),
    .go       (send_go),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .sent     (sent)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    send_go    = 1'b0;
    send_byte  = bytes.hi;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (length == '0) ? AFTER_LAST : RD_ISSUE;
        end
      end
      RD_ISSUE: next_state = RD_WAIT;
      RD_WAIT:  next_state = SEND_HI;
      SEND_HI: begin
        send_go = 1'b1;
        if (tx_start) next_state = WAIT_HI;
      end
      WAIT_HI: begin
        if (sent) next_state = SEND_LO;
      end
      SEND_LO: begin
        send_byte = bytes.lo;
        send_go   = 1'b1;
        if (tx_start) next_state = WAIT_LO;
      end
      WAIT_LO: begin
        send_byte = bytes.lo;
        if (sent) next_state = (cnt_next == len_q) ? AFTER_LAST : RD_ISSUE;
      end
`ifdef READOUT_CHECKSUM_EN
      CHK_SEND: begin
        send_byte = csum;
        send_go   = 1'b1;
        if (tx_start) next_state = CHK_WAIT;
      end
      CHK_WAIT: begin
        send_byte = csum;
        if (sent) next_state = DONE;
      end
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      word_cnt  <= '0;
      bram_addr <= '0;
      word_q    <= 16'h0000;
    end else begin
      if (accept) begin
        len_q     <= (length > MAX_LEN) ? MAX_LEN : length;
        word_cnt  <= '0;
        bram_addr <= '0;
      end
      if (state == RD_WAIT) begin
        word_q <= 16'(bram_dout);
      end
      if (word_done) begin
        word_cnt <= cnt_next;
        if (cnt_next != len_q) begin
          bram_addr <= (bram_addr == LAST_ADDR) ? '0 : bram_addr + 1'b1;
        end
      end
    end
  end

`ifdef READOUT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      csum <= 8'h00;
    end else if (tx_start && (state != CHK_SEND)) begin
      csum <= csum ^ tx_data;
    end
  end
`endif

endmodule
